aes_key_expand: RTL
===================

Name: aes_key_expand

Overview:
Iterative AES-128 key-schedule generator. Produces the 11 round keys (round 0..10), one per accepted handshake, from a 128-bit cipher key. Computes SubWord with four combinational s_box instances in the RotWord path. Sits upstream of the round datapath, which consumes each round key through a valid/ready handshake.

Parameters:
NR, 10, index of the last round key produced (fixed for AES-128; other values are unsupported).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin expansion; sampled only in IDLE
key_in  input  128  cipher key, big-endian word order (w0 = key_in[127:96]); sampled on accepted start
rk_ready  input  1  consumer accepts round_key this cycle
round_key  output  128  current round key, {w[4r], w[4r+1], w[4r+2], w[4r+3]}
round_idx  output  4  round number r of round_key (0..NR)
rk_valid  output  1  round_key/round_idx valid
busy  output  1  high from accepted start until final key accepted
done  output  1  one-cycle pulse on the cycle the round-NR key is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: round_key = 0, round_idx = 0, rk_valid = 0, busy = 0, done = 0, rcon register = 8'h01, state = IDLE.
- States: IDLE, EMIT.
- IDLE, start=1 at edge T:
  - Register key_in into round_key; round_idx = 0; rcon = 8'h01.
  - Set rk_valid = 1 and busy = 1 → enter EMIT. Round 0 is visible from cycle T+1.
- IDLE, start=0: outputs hold, with rk_valid = 0.
- EMIT, at each edge with rk_valid & rk_ready (transfer):
  - If round_idx < NR:
    - round_key ← next key; round_idx += 1.
    - rcon ← xtime(rcon): shift left 1; if bit 7 was set, XOR 8'h1b.
    - rk_valid stays 1, so a sustained rk_ready yields one key per cycle.
  - If round_idx == NR:
    - rk_valid → 0, busy → 0, state → IDLE.
    - done = 1 for exactly that one cycle (registered pulse).
- Next key, combinational from the registered round_key:
  - t = SubWord(RotWord(w3)) XOR {rcon, 24'h0}.
  - RotWord: {b1, b2, b3, b0}. SubWord: four s_box lookups, one per byte.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- Rcon sequence applied for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
- Stall: while rk_valid & !rk_ready, round_key, round_idx and rcon hold stable; no key is skipped or recomputed.
- start is ignored while busy = 1, including on the done cycle. A new start is accepted no earlier than the cycle after done.
- rst asserted mid-expansion: next edge applies full reset values, no done pulse, and the partial schedule is discarded.
- Latency: start edge → round 0 valid is 1 cycle. With rk_ready held high, done occurs at edge T+11, coincident with acceptance of round 10.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 → round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; 11 consecutive valid cycles; done on 11th transfer; busy low afterwards.
- All-zero key → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- FIPS key, rk_ready low for 3 cycles at round 4 and for 1 cycle at round 9 → round_key and round_idx stable while stalled; full sequence identical to the unstalled run; done only on round-10 acceptance.
- start pulsed with a different key while busy (round 5) → ignored; remaining keys still follow the original key.
- rst asserted at round 6 → next cycle rk_valid=0, busy=0, round_idx=0, no done; a subsequent start with the FIPS key reproduces scenario 1 exactly.
- Back-to-back runs: start asserted the cycle after done with the zero key → round 0 = 0 one cycle later; rcon restarts at 01 (round 1 matches scenario 2).

Source files
------------

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NR one per accepted
// valid/ready transfer, deriving each key from the previously emitted one.

module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Row r holds entries 16r..16r+15; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  always_comb begin
    base = {3'b000, ~a} << 3;
    y    = SBOX[base +: 8];
  end
endmodule

module aes_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  localparam logic [3:0] LAST = NR[3:0];

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_next;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
  logic        accept, xfer, last;

  assign w0  = round_key[127:96];
  assign w1  = round_key[95:64];
  assign w2  = round_key[63:32];
  assign w3  = round_key[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  s_box u_sb3 (.a(rot[31:24]), .y(sub[31:24]));
  s_box u_sb2 (.a(rot[23:16]), .y(sub[23:16]));
  s_box u_sb1 (.a(rot[15:8]),  .y(sub[15:8]));
  s_box u_sb0 (.a(rot[7:0]),   .y(sub[7:0]));

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // A start seen while the done pulse is still up belongs to the run just
  // finished, so it is held off until the following cycle.
  assign accept = (state == IDLE) && start && !done;
  assign xfer   = (state == EMIT) && rk_ready;
  assign last   = (round_idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)      state_next = EMIT;
      EMIT: if (xfer && last) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    rk_valid = (state == EMIT);
    busy     = (state == EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_key <= '0;
      round_idx <= '0;
      rcon      <= 8'h01;
      done      <= 1'b0;
    end else begin
      done <= xfer && last;
      if (accept) begin
        round_key <= key_in;
        round_idx <= '0;
        rcon      <= 8'h01;
      end else if (xfer && !last) begin
        round_key <= {n0, n1, n2, n3};
        round_idx <= round_idx + 4'd1;
        rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end
endmodule
